// File: rtl/sdram_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_sched_if
// Purpose  : Request/grant/status bundle between SDRAM clients and scheduler.
// Revision : 1.0
// ============================================================================
interface sdram_sched_if;
    logic        wr_req;
    logic        wr_done;
    logic        rd_req;
    logic        rd_done;
    logic        ref_ack;
    logic        eofavc;
    logic        wr_gnt;
    logic        rd_gnt;
    logic        ref_req;
    logic        busy;
    logic [2:0]  ref_pend;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic [1:0]  err;

    modport master (
        output wr_req, wr_done, rd_req, rd_done, ref_ack, eofavc,
        input  wr_gnt, rd_gnt, ref_req, busy, ref_pend, wr_cnt, rd_cnt, err
    );

    modport slave (
        input  wr_req, wr_done, rd_req, rd_done, ref_ack, eofavc,
        output wr_gnt, rd_gnt, ref_req, busy, ref_pend, wr_cnt, rd_cnt, err
    );
endinterface
`default_nettype wire

// File: rtl/sdram_sched.sv
`default_nettype none
// ============================================================================
// Module   : sdram_sched
// Purpose  : Single-owner SDRAM access scheduler: write/read/refresh
//            arbitration, turnaround gap, refresh accounting and watchdog.
// Revision : 1.0
// ============================================================================
module sdram_sched #(
    parameter int REF_INTERVAL = 780,
    parameter int REF_URGENT   = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int WDOG_CYCLES  = 4096
) (
    input  wire logic    clk,
    input  wire logic    reset,
    sdram_sched_if.slave bus
);

    localparam int c_TMR_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int c_DW    = $clog2((WDOG_CYCLES > GAP_CYCLES) ? WDOG_CYCLES : GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_REF  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_TMR_W-1:0] r_tmr;
    logic [2:0]         r_pend;
    logic [c_DW-1:0]    r_dwell;
    logic [15:0]        r_wr_cnt;
    logic [15:0]        r_rd_cnt;
    logic [1:0]         r_err;

    logic w_tick;
    logic w_dec;
    logic w_wdog_exp;
    logic w_gap_end;
    logic w_wr_inc;
    logic w_rd_inc;
    logic w_wdog_err;

    assign w_tick     = (r_tmr == '0);
    assign w_dec      = bus.ref_ack && (r_pend != 3'd0);
    assign w_wdog_exp = (r_dwell == c_DW'(WDOG_CYCLES - 1));
    assign w_gap_end  = (r_dwell == c_DW'(GAP_CYCLES - 1));

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_wr_inc   = 1'b0;
        w_rd_inc   = 1'b0;
        w_wdog_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend >= 3'(REF_URGENT))            w_next = S_REF;
                else if (bus.rd_req)                     w_next = S_RD;
                else if (bus.wr_req && !bus.eofavc)      w_next = S_WR;
                else if (r_pend != 3'd0)                 w_next = S_REF;
            end
            S_WR: begin
                if (bus.wr_done) begin
                    w_next   = S_GAP;
                    w_wr_inc = 1'b1;
                end else if (w_wdog_exp) begin
                    w_next     = S_GAP;
                    w_wdog_err = 1'b1;
                end
            end
            S_RD: begin
                if (bus.rd_done) begin
                    w_next   = S_GAP;
                    w_rd_inc = 1'b1;
                end else if (w_wdog_exp) begin
                    w_next     = S_GAP;
                    w_wdog_err = 1'b1;
                end
            end
            S_REF: begin
                if (bus.ref_ack) begin
                    w_next = S_GAP;
                end else if (w_wdog_exp) begin
                    w_next     = S_GAP;
                    w_wdog_err = 1'b1;
                end
            end
            S_GAP: begin
                if (w_gap_end) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // One dwell counter serves both the watchdog and the gap: it restarts on
    // every state change, so each owner and each gap counts from zero.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_tmr    <= c_TMR_W'(REF_INTERVAL - 1);
            r_pend   <= 3'd0;
            r_dwell  <= '0;
            r_wr_cnt <= 16'd0;
            r_rd_cnt <= 16'd0;
            r_err    <= 2'b00;
        end else begin
            r_tmr <= w_tick ? c_TMR_W'(REF_INTERVAL - 1) : r_tmr - 1'b1;

            if (w_tick && !w_dec) begin
                if (r_pend == 3'd7) r_err[0] <= 1'b1;
                else                r_pend   <= r_pend + 3'd1;
            end else if (!w_tick && w_dec) begin
                r_pend <= r_pend - 3'd1;
            end

            if (w_next != r_state)     r_dwell <= '0;
            else if (r_state != S_IDLE) r_dwell <= r_dwell + 1'b1;

            if (w_wr_inc)   r_wr_cnt <= r_wr_cnt + 16'd1;
            if (w_rd_inc)   r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_wdog_err) r_err[1] <= 1'b1;
        end
    end

    assign bus.wr_gnt   = (r_state == S_WR);
    assign bus.rd_gnt   = (r_state == S_RD);
    assign bus.ref_req  = (r_state == S_REF);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.ref_pend = r_pend;
    assign bus.wr_cnt   = r_wr_cnt;
    assign bus.rd_cnt   = r_rd_cnt;
    assign bus.err      = r_err;

endmodule
`default_nettype wire
